// File: rtl/sw_run_monitor_pkg.sv
// sw_run_monitor shared types and widths.
// State encodings and summary record sizing.
`define SW_MON_SUM_W(q, k, t, c) ((q) + (k) * ((t) + (c)) + 1)

package sw_run_monitor_pkg;

  localparam int CALC_BIT      = 12;
  localparam int MAX_T_NUM_BIT = 10;

  typedef enum logic [1:0] {
    SW_MON_IDLE    = 2'd0,
    SW_MON_RUN     = 2'd1,
    SW_MON_DONE    = 2'd2,
    SW_MON_TIMEOUT = 2'd3
  } sw_mon_state_e;

endpackage

// File: rtl/sw_run_monitor_if.sv
// Core-side and summary-side signals of the run monitor.
// master = monitor, slave = core plus summary consumer.
interface sw_run_monitor_if #(
  parameter int CALC_BIT  = 12,
  parameter int T_IDX_BIT = 10,
  parameter int Q_IDX_BIT = 8,
  parameter int TOP_K     = 2
);
  logic                       start_o;
  logic                       busy_i;
  logic                       valid_i;
  logic [CALC_BIT-1:0]        result_i;
  logic                       change_q_i;
  logic [T_IDX_BIT-1:0]       match_idx_i;
  logic [CALC_BIT-1:0]        max_result_i;
  logic                       sum_valid_o;
  logic                       sum_ready_i;
  logic [Q_IDX_BIT-1:0]       sum_q_idx_o;
  logic [TOP_K*T_IDX_BIT-1:0] sum_idx_o;
  logic [TOP_K*CALC_BIT-1:0]  sum_score_o;
  logic                       sum_mismatch_o;

  modport master (
    output start_o,
    input  busy_i, valid_i, result_i,
    input  change_q_i, match_idx_i,
    input  max_result_i,
    output sum_valid_o,
    input  sum_ready_i,
    output sum_q_idx_o, sum_idx_o,
    output sum_score_o, sum_mismatch_o
  );

  modport slave (
    input  start_o,
    output busy_i, valid_i, result_i,
    output change_q_i, match_idx_i,
    output max_result_i,
    input  sum_valid_o,
    output sum_ready_i,
    input  sum_q_idx_o, sum_idx_o,
    input  sum_score_o, sum_mismatch_o
  );
endinterface

// File: rtl/sw_topk_insert.sv
// Combinational sorted insert into a descending top-K list.
// Ties keep the earlier entry; empty slots lose to anything.
module sw_topk_insert #(
  parameter int CALC_BIT  = 12,
  parameter int T_IDX_BIT = 10,
  parameter int TOP_K     = 2
) (
  input  logic [TOP_K-1:0][T_IDX_BIT-1:0] i_idx,
  input  logic [TOP_K-1:0][CALC_BIT-1:0]  i_score,
  input  logic [TOP_K-1:0]                i_vld,
  input  logic [T_IDX_BIT-1:0]            i_new_idx,
  input  logic [CALC_BIT-1:0]             i_new_score,
  output logic [TOP_K-1:0][T_IDX_BIT-1:0] o_idx,
  output logic [TOP_K-1:0][CALC_BIT-1:0]  o_score,
  output logic [TOP_K-1:0]                o_vld
);

  // w_gt is monotone: once the new score wins a slot it wins all below
  logic [TOP_K-1:0] w_gt;

  for (genvar j = 0; j < TOP_K; j++) begin : g_slot
    assign w_gt[j] = ~i_vld[j]
                   | (i_new_score > i_score[j]);
    if (j == 0) begin : g_head
      assign o_idx[j]   = w_gt[j] ? i_new_idx
                                  : i_idx[j];
      assign o_score[j] = w_gt[j] ? i_new_score
                                  : i_score[j];
      assign o_vld[j]   = w_gt[j] | i_vld[j];
    end else begin : g_tail
      logic w_here;
      assign w_here = w_gt[j] & ~w_gt[j-1];
      assign o_idx[j] = w_here  ? i_new_idx
                      : w_gt[j] ? i_idx[j-1]
                      : i_idx[j];
      assign o_score[j] = w_here  ? i_new_score
                        : w_gt[j] ? i_score[j-1]
                        : i_score[j];
      assign o_vld[j] = w_here
                      | (w_gt[j] ? i_vld[j-1]
                                 : i_vld[j]);
    end
  end

endmodule

// File: rtl/sw_run_monitor.sv
// Run controller and result monitor for the SmithWaterman core.
// Launches runs, ranks results per query, queues summaries.
module sw_run_monitor
  import sw_run_monitor_pkg::*;
#(
  parameter int CALC_BIT   = sw_run_monitor_pkg::CALC_BIT,
  parameter int T_IDX_BIT  = MAX_T_NUM_BIT,
  parameter int Q_IDX_BIT  = 8,
  parameter int TOP_K      = 2,
  parameter int FIFO_DEPTH = 8,
  parameter int WD_BIT     = 20
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              go_i,
  input  logic [WD_BIT-1:0] wd_limit_i,
  sw_run_monitor_if.master  bus,
  output logic [1:0]        state_o,
  output logic              overflow_o,
  output logic [Q_IDX_BIT-1:0] q_count_o
);

  localparam int SUM_W =
    `SW_MON_SUM_W(Q_IDX_BIT, TOP_K, T_IDX_BIT, CALC_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);

  sw_mon_state_e r_state;
  sw_mon_state_e w_state_nxt;

  logic                 r_start;
  logic                 r_busy_d;
  logic [WD_BIT-1:0]    r_wd_lim;
  logic [WD_BIT-1:0]    r_wd;
  logic [T_IDX_BIT-1:0] r_t_idx;
  logic [Q_IDX_BIT-1:0] r_q_idx;
  logic [Q_IDX_BIT-1:0] r_q_cnt;
  logic                 r_ovf;

  logic [TOP_K-1:0][T_IDX_BIT-1:0] r_rk_idx;
  logic [TOP_K-1:0][CALC_BIT-1:0]  r_rk_sc;
  logic [TOP_K-1:0]                r_rk_vld;
  logic [TOP_K-1:0][T_IDX_BIT-1:0] w_ins_idx;
  logic [TOP_K-1:0][CALC_BIT-1:0]  w_ins_sc;
  logic [TOP_K-1:0]                w_ins_vld;

  logic [SUM_W-1:0] r_mem [FIFO_DEPTH];
  logic [AW:0]      r_wr;
  logic [AW:0]      r_rd;

  logic              w_launch;
  logic              w_run;
  logic              w_fall;
  logic [WD_BIT-1:0] w_wd_inc;
  logic              w_wd_hit;
  logic              w_step;
  logic              w_qend;
  logic              w_mm;
  logic [SUM_W-1:0]  w_sum_in;
  logic [SUM_W-1:0]  w_head;
  logic              w_empty;
  logic              w_full;
  logic              w_pop;
  logic              w_push;
  logic              w_drop;

  assign w_run    = (r_state == SW_MON_RUN);
  assign w_launch = go_i & ~w_run;
  assign w_fall   = r_busy_d & ~bus.busy_i;
  assign w_wd_inc = (&r_wd) ? r_wd : r_wd + 1'b1;
  assign w_wd_hit = (r_wd_lim != '0)
                  & (w_wd_inc == r_wd_lim);
  assign w_step   = w_run & bus.valid_i;
  assign w_qend   = w_step & bus.change_q_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= SW_MON_IDLE;
    else        r_state <= w_state_nxt;
  end

  // busy fall is checked first so it wins a same-cycle timeout
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      SW_MON_RUN: begin
        if (w_fall)        w_state_nxt = SW_MON_DONE;
        else if (w_wd_hit) w_state_nxt = SW_MON_TIMEOUT;
      end
      default: begin
        if (go_i) w_state_nxt = SW_MON_RUN;
      end
    endcase
  end

  always_comb begin
    state_o     = r_state;
    bus.start_o = r_start;
    overflow_o  = r_ovf;
    q_count_o   = r_q_cnt;
  end

  sw_topk_insert #(
    .CALC_BIT  (CALC_BIT),
    .T_IDX_BIT (T_IDX_BIT),
    .TOP_K     (TOP_K)
  ) u_ins (
    .i_idx       (r_rk_idx),
    .i_score     (r_rk_sc),
    .i_vld       (r_rk_vld),
    .i_new_idx   (r_t_idx),
    .i_new_score (bus.result_i),
    .o_idx       (w_ins_idx),
    .o_score     (w_ins_sc),
    .o_vld       (w_ins_vld)
  );

  assign w_mm = (bus.match_idx_i != w_ins_idx[0])
              | (bus.max_result_i != w_ins_sc[0]);
  assign w_sum_in = {r_q_idx, w_ins_idx,
                     w_ins_sc, w_mm};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_start  <= 1'b0;
      r_busy_d <= 1'b0;
      r_wd_lim <= '0;
      r_wd     <= '0;
      r_t_idx  <= '0;
      r_q_idx  <= '0;
      r_q_cnt  <= '0;
      r_rk_idx <= '0;
      r_rk_sc  <= '0;
      r_rk_vld <= '0;
    end else begin
      r_start  <= w_launch;
      r_busy_d <= bus.busy_i;
      if (w_launch) begin
        r_wd_lim <= wd_limit_i;
        r_wd     <= '0;
        r_t_idx  <= '0;
        r_q_idx  <= '0;
        r_q_cnt  <= '0;
        r_rk_idx <= '0;
        r_rk_sc  <= '0;
        r_rk_vld <= '0;
      end else if (w_run) begin
        r_wd <= w_wd_inc;
        if (w_qend) begin
          r_t_idx  <= '0;
          r_q_idx  <= r_q_idx + 1'b1;
          r_q_cnt  <= r_q_cnt + 1'b1;
          r_rk_idx <= '0;
          r_rk_sc  <= '0;
          r_rk_vld <= '0;
        end else if (w_step) begin
          r_t_idx  <= r_t_idx + 1'b1;
          r_rk_idx <= w_ins_idx;
          r_rk_sc  <= w_ins_sc;
          r_rk_vld <= w_ins_vld;
        end
      end
    end
  end

  assign w_empty = (r_wr == r_rd);
  assign w_full  = (r_wr[AW] != r_rd[AW])
                 & (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign w_pop   = ~w_empty & bus.sum_ready_i;
  assign w_push  = w_qend & (~w_full | w_pop);
  assign w_drop  = w_qend & w_full & ~w_pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_ovf <= 1'b0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      if (w_launch)    r_ovf <= 1'b0;
      else if (w_drop) r_ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr[AW-1:0]] <= w_sum_in;
  end

  // head is forced to zero when empty so reset shows all-zero outputs
  assign w_head = w_empty ? '0
                          : r_mem[r_rd[AW-1:0]];

  always_comb begin
    bus.sum_valid_o = ~w_empty;
    {bus.sum_q_idx_o, bus.sum_idx_o,
     bus.sum_score_o, bus.sum_mismatch_o} = w_head;
  end

endmodule

// File: tb/tb_sw_run_monitor.sv
// Scoreboard bench for sw_run_monitor.
// Reference top-K model feeds an expected-summary queue.
module tb_sw_run_monitor;

  localparam int CW = 12;
  localparam int TW = 10;
  localparam int QW = 8;
  localparam int K  = 2;
  localparam int FD = 8;
  localparam int WW = 20;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          go_i = 1'b0;
  logic [WW-1:0] wd_limit_i = '0;
  logic [1:0]    state_o;
  logic          overflow_o;
  logic [QW-1:0] q_count_o;

  sw_run_monitor_if #(
    .CALC_BIT(CW), .T_IDX_BIT(TW),
    .Q_IDX_BIT(QW), .TOP_K(K)
  ) bus ();

  sw_run_monitor #(
    .CALC_BIT(CW), .T_IDX_BIT(TW),
    .Q_IDX_BIT(QW), .TOP_K(K),
    .FIFO_DEPTH(FD), .WD_BIT(WW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .go_i       (go_i),
    .wd_limit_i (wd_limit_i),
    .bus        (bus),
    .state_o    (state_o),
    .overflow_o (overflow_o),
    .q_count_o  (q_count_o)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  logic [63:0] sbq [$];

  int unsigned m_sc [K];
  int unsigned m_ix [K];
  int          m_n;
  int unsigned m_t;
  int unsigned m_q;
  int unsigned m_qc;
  int          m_fc;
  bit          m_ovf;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic m_clear;
    for (int j = 0; j < K; j++) begin
      m_sc[j] = 0;
      m_ix[j] = 0;
    end
    m_n = 0;
    m_t = 0;
  endtask

  task automatic m_insert(input int unsigned s,
                          input int unsigned ti);
    int p;
    p = m_n;
    for (int j = 0; j < m_n; j++) begin
      if (m_sc[j] < s) begin
        p = j;
        break;
      end
    end
    if (p < K) begin
      for (int j = K - 1; j > p; j--) begin
        m_sc[j] = m_sc[j-1];
        m_ix[j] = m_ix[j-1];
      end
      m_sc[p] = s;
      m_ix[p] = ti;
      if (m_n < K) m_n++;
    end
  endtask

  task automatic go(input int unsigned lim);
    go_i = 1'b1;
    wd_limit_i = WW'(lim);
    tick();
    go_i = 1'b0;
    m_clear();
    m_q = 0;
    m_qc = 0;
    m_ovf = 1'b0;
  endtask

  task automatic feed(input int unsigned s,
                      input bit last,
                      input int unsigned mi,
                      input int unsigned mx);
    logic [63:0] v;
    bus.valid_i = 1'b1;
    bus.result_i = CW'(s);
    bus.change_q_i = last;
    bus.match_idx_i = TW'(mi);
    bus.max_result_i = CW'(mx);
    m_insert(s, m_t);
    m_t++;
    if (last) begin
      v = 64'(QW'(m_q));
      for (int j = K - 1; j >= 0; j--)
        v = (v << TW) | 64'(TW'(m_ix[j]));
      for (int j = K - 1; j >= 0; j--)
        v = (v << CW) | 64'(CW'(m_sc[j]));
      v = (v << 1) |
          64'((mi != m_ix[0]) || (mx != m_sc[0]));
      if (m_fc < FD) begin
        sbq.push_back(v);
        m_fc++;
      end else begin
        m_ovf = 1'b1;
      end
      m_clear();
      m_q = (m_q + 1) % 256;
      m_qc = (m_qc + 1) % 256;
    end
    tick();
    bus.valid_i = 1'b0;
    bus.change_q_i = 1'b0;
  endtask

  task automatic pop_one;
    int w;
    logic [63:0] got;
    w = 0;
    while (!bus.sum_valid_o && w < 50) begin
      tick();
      w++;
    end
    if (!bus.sum_valid_o) begin
      check("pop_timeout", 64'(bus.sum_valid_o), 64'd1);
    end else if (sbq.size() == 0) begin
      check("sb_empty", 64'(bus.sum_valid_o), 64'd0);
    end else begin
      got = 64'({bus.sum_q_idx_o, bus.sum_idx_o,
                 bus.sum_score_o, bus.sum_mismatch_o});
      check("summary", got, sbq.pop_front());
      m_fc--;
      bus.sum_ready_i = 1'b1;
      tick();
      bus.sum_ready_i = 1'b0;
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_a"},
          64'({bus.start_o, bus.sum_valid_o,
               bus.sum_q_idx_o, bus.sum_mismatch_o,
               state_o, overflow_o, q_count_o}),
          64'd0);
    check({tag, "_b"},
          64'({bus.sum_idx_o, bus.sum_score_o}),
          64'd0);
  endtask

  initial begin
    int n;
    int len;
    bus.busy_i = 1'b0;
    bus.valid_i = 1'b0;
    bus.result_i = '0;
    bus.change_q_i = 1'b0;
    bus.match_idx_i = '0;
    bus.max_result_i = '0;
    bus.sum_ready_i = 1'b0;
    m_clear();
    m_q = 0;
    m_qc = 0;
    m_fc = 0;
    m_ovf = 1'b0;

    repeat (3) tick();
    check_zero("reset");
    rst_n = 1'b1;
    tick();

    go(100);
    check("start_hi", 64'(bus.start_o), 64'd1);
    check("state_run", 64'(state_o), 64'd1);
    bus.busy_i = 1'b1;
    tick();
    check("start_lo", 64'(bus.start_o), 64'd0);

    feed(5, 0, 1, 9);
    feed(9, 0, 1, 9);
    feed(9, 0, 1, 9);
    feed(3, 1, 1, 9);
    check("qcnt1", 64'(q_count_o), 64'd1);
    check("q0_idx", 64'(bus.sum_idx_o),
          64'({10'd2, 10'd1}));
    check("q0_sc", 64'(bus.sum_score_o),
          64'({12'd9, 12'd9}));
    check("q0_mm", 64'(bus.sum_mismatch_o), 64'd0);
    pop_one();

    feed(5, 0, 2, 9);
    feed(9, 0, 2, 9);
    feed(9, 0, 2, 9);
    feed(3, 1, 2, 9);
    check("q1_mm", 64'(bus.sum_mismatch_o), 64'd1);
    check("q1_q", 64'(bus.sum_q_idx_o), 64'd1);
    pop_one();

    bus.busy_i = 1'b0;
    tick();
    check("state_done", 64'(state_o), 64'd2);

    go(0);
    bus.busy_i = 1'b1;
    for (int q = 0; q < 9; q++) begin
      len = int'($urandom_range(1, 5));
      for (int k = 0; k < len; k++)
        feed($urandom_range(0, 20), k == len - 1,
             $urandom_range(0, 3),
             $urandom_range(0, 20));
    end
    check("qcnt9", 64'(q_count_o), 64'(m_qc));
    check("ovf_set", 64'(overflow_o), 64'(m_ovf));
    for (int i = 0; i < FD; i++) pop_one();
    check("fifo_empty", 64'(bus.sum_valid_o), 64'd0);
    check("ovf_sticky", 64'(overflow_o), 64'd1);
    bus.busy_i = 1'b0;
    tick();
    check("state_done2", 64'(state_o), 64'd2);

    go(50);
    check("ovf_clr", 64'(overflow_o), 64'd0);
    bus.busy_i = 1'b1;
    n = 0;
    while (state_o == 2'd1 && n < 200) begin
      n++;
      tick();
    end
    check("wd_cycles", 64'(n), 64'd50);
    check("state_to", 64'(state_o), 64'd3);

    go(0);
    repeat (300) tick();
    check("wd_off", 64'(state_o), 64'd1);

    feed(6, 1, 0, 6);
    feed(2, 0, 0, 0);
    feed(8, 0, 0, 0);
    check("pre_rst_vld", 64'(bus.sum_valid_o), 64'd1);
    rst_n = 1'b0;
    #1;
    check_zero("midrst");
    sbq.delete();
    m_fc = 0;
    bus.busy_i = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    check("rst_idle", 64'(state_o), 64'd0);

    go(0);
    bus.busy_i = 1'b1;
    tick();
    feed(4, 0, 1, 7);
    feed(7, 1, 1, 7);
    check("q_restart", 64'(bus.sum_q_idx_o), 64'd0);
    check("qcnt_r", 64'(q_count_o), 64'd1);
    pop_one();
    bus.busy_i = 1'b0;
    tick();
    check("state_done3", 64'(state_o), 64'd2);
    bus.valid_i = 1'b1;
    bus.change_q_i = 1'b1;
    tick();
    bus.valid_i = 1'b0;
    bus.change_q_i = 1'b0;
    tick();
    check("idle_vld", 64'(bus.sum_valid_o), 64'd0);
    check("idle_qcnt", 64'(q_count_o), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
